decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, handshaked RV32I/RV32E decode stage between fetch and execute.
- Decodes all base opcodes into control fields and one selected immediate, and flags illegal encodings.
- Tracks pending register writes in a scoreboard and stalls read-after-write and write-after-write hazards.
- One output pipeline register; flush drops the held instruction.

Parameters:
XLEN, 32, datapath width; immediates and pc are sign-extended/held at XLEN (XLEN >= 32)
NUM_REGS, 32, architectural register count (32 = RV32I, 16 = RV32E); any rs1/rs2/rd index >= NUM_REGS that the instruction uses is illegal
SB_EN, 1, 1 = scoreboard and hazard stall enabled; 0 = no stall, busy logic removed

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  fetch presents instr/pc
in_ready  out  1  decode accepts this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded instruction held
out_ready  in  1  execute accepts
out_pc  out  XLEN  registered pc
out_rd/out_rs1/out_rs2  out  5 each  register indices
out_alu_op  out  alu_op_t  ALU operation
out_br_op  out  4  {1, funct3} for BRANCH, else 0
out_imm  out  XLEN  immediate selected by format (I/S/B/U/J); 0 for R-type
out_is_imm  out  1  ALU operand B is the immediate
out_reg_we  out  1  writes rd (forced 0 when rd == 0)
out_mem_re / out_mem_we  out  1 each  load / store
out_mem_size  out  3  funct3 for load/store, else 0
out_jal / out_jalr / out_lui / out_auipc  out  1 each  opcode flags
out_illegal  out  1  illegal encoding
flush  in  1  squash the held instruction
wb_valid  in  1  writeback completes
wb_rd  in  5  register written back

Behaviour:
- Reset: out_valid = 0, all out_* = 0, out_alu_op = i_NOP, scoreboard busy[] all 0.
- Decode rules:
  - OP_IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI; SLLI with funct7 = 0; SRLI with funct7 = 0; SRAI with funct7 = 0100000.
  - OP_REG: the 10 base funct7/funct3 combinations.
  - LOAD: funct3 in {000, 001, 010, 100, 101}; alu_op = i_ADD, is_imm = 1.
  - STORE: funct3 in {000, 001, 010}; alu_op = i_ADD, is_imm = 1.
  - BRANCH: funct3 not in {010, 011}.
  - JALR: funct3 = 000.
  - LUI, AUIPC, JAL: accepted as-is.
- Illegal: anything else, including a used index >= NUM_REGS. Then out_illegal = 1, reg_we / mem_re / mem_we = 0, alu_op = i_NOP; the instruction still flows through the handshake.
- Source use:
  - rs1 is read by OP_IMM, OP_REG, LOAD, STORE, BRANCH and JALR.
  - rs2 is read by OP_REG, STORE and BRANCH.
  - x0 is never busy.
- hazard (SB_EN = 1 only) is asserted when any of:
  - a used rs1 or rs2 is busy;
  - reg_we is set and busy[rd] is set.
- Writeback bypass: wb_valid && wb_rd == idx counts as not busy in the same cycle.
- Illegal instructions never stall.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Transfer occurs when in_valid && in_ready. The decoded fields are registered and out_valid = 1 next cycle; latency is 1 cycle.
  - Output transfer occurs when out_valid && out_ready. If no new transfer happens in the same cycle, out_valid drops to 0.
  - Back-to-back transfers give a throughput of one instruction per cycle.
  - Outputs stay stable while out_valid && !out_ready.
- Scoreboard:
  - On input transfer with reg_we: busy[rd] is set.
  - On wb_valid: busy[wb_rd] is cleared.
  - If set and clear hit the same index in the same cycle, set wins.
  - WAW stall guarantees at most one pending writer per register.
- Flush:
  - Next cycle out_valid = 0.
  - If the held instruction had reg_we, its busy[out_rd] is cleared.
  - No input transfer happens during a flush cycle.
  - Flush has priority over out_ready.
- Reset mid-operation clears out_valid and all busy bits immediately (asynchronous).

Test Plan:
- Decode coverage, idle bus: addi x1,x0,5 (0x00500093) -> one cycle later out_valid = 1, rd = 1, alu_op = i_ADD, imm = 5, is_imm = 1, reg_we = 1. srai x2,x1,3 (0x4030D113) -> alu_op = i_SRA, imm = 3.
- Immediates and illegal: beq with offset −4 -> br_op = 4'b1000, imm = 0xFFFFFFFC. Opcode 0x7F -> out_illegal = 1, reg_we = 0, no busy bit set.
- RAW stall: issue add x3,x1,x2, then sub x4,x3,x1 -> in_ready = 0 until wb_valid with wb_rd = 3; in that same cycle in_ready = 1 (bypass), and sub is accepted.
- Backpressure: out_ready = 0 for 3 cycles with a valid output -> outputs held constant, in_ready = 0; out_ready = 1 -> the next instruction transfers back-to-back.
- Flush: addi x5 held with out_ready = 0, flush = 1 -> next cycle out_valid = 0, busy[5] = 0; a following read of x5 does not stall.
- Parameters: NUM_REGS = 16 with add x17,x1,x2 -> out_illegal = 1. SB_EN = 0 with the RAW sequence -> no stall, one instruction per cycle.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: turns a fetched word into registered control fields,
// flags illegal encodings, and stalls on RAW/WAW hazards against pending writebacks.
package decode_stage_pkg;
    typedef enum logic [3:0] {
        i_NOP  = 4'd0,
        i_ADD  = 4'd1,
        i_SUB  = 4'd2,
        i_SLL  = 4'd3,
        i_SLT  = 4'd4,
        i_SLTU = 4'd5,
        i_XOR  = 4'd6,
        i_SRL  = 4'd7,
        i_SRA  = 4'd8,
        i_OR   = 4'd9,
        i_AND  = 4'd10
    } alu_op_t;
endpackage

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter bit SB_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output alu_op_t         out_alu_op,
    output logic [3:0]      out_br_op,
    output logic [XLEN-1:0] out_imm,
    output logic            out_is_imm,
    output logic            out_reg_we,
    output logic            out_mem_re,
    output logic            out_mem_we,
    output logic [2:0]      out_mem_size,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_lui,
    output logic            out_auipc,
    output logic            out_illegal,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        alu_op_t         alu_op;
        logic [3:0]      br_op;
        logic [2:0]      mem_size;
        logic            is_imm;
        logic            reg_we;
        logic            mem_re;
        logic            mem_we;
        logic            jal;
        logic            jalr;
        logic            lui;
        logic            auipc;
        logic            illegal;
    } dec_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    dec_t dec;
    dec_t out_q;
    logic legal, bad_idx, use_rs1, use_rs2, has_rd;
    logic hazard;
    logic in_fire;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i  = XLEN'($signed(in_instr[31:20]));
    assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    assign imm_sh = XLEN'(in_instr[24:20]);

    function automatic logic idx_bad(input logic [4:0] idx);
        return 32'(idx) >= NUM_REGS;
    endfunction

    always_comb begin
        dec      = '0;
        dec.pc   = in_pc;
        dec.rd   = in_instr[11:7];
        dec.rs1  = in_instr[19:15];
        dec.rs2  = in_instr[24:20];
        legal    = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        has_rd   = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                use_rs1    = 1'b1;
                has_rd     = 1'b1;
                dec.is_imm = 1'b1;
                dec.imm    = imm_i;
                legal      = 1'b1;
                case (funct3)
                    3'b000: dec.alu_op = i_ADD;
                    3'b010: dec.alu_op = i_SLT;
                    3'b011: dec.alu_op = i_SLTU;
                    3'b100: dec.alu_op = i_XOR;
                    3'b110: dec.alu_op = i_OR;
                    3'b111: dec.alu_op = i_AND;
                    3'b001: begin
                        dec.alu_op = i_SLL;
                        dec.imm    = imm_sh;
                        legal      = (funct7 == 7'b0000000);
                    end
                    default: begin
                        dec.imm = imm_sh;
                        if (funct7 == 7'b0000000)
                            dec.alu_op = i_SRL;
                        else if (funct7 == 7'b0100000)
                            dec.alu_op = i_SRA;
                        else
                            legal = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                has_rd  = 1'b1;
                legal   = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: dec.alu_op = i_ADD;
                    10'b0100000_000: dec.alu_op = i_SUB;
                    10'b0000000_001: dec.alu_op = i_SLL;
                    10'b0000000_010: dec.alu_op = i_SLT;
                    10'b0000000_011: dec.alu_op = i_SLTU;
                    10'b0000000_100: dec.alu_op = i_XOR;
                    10'b0000000_101: dec.alu_op = i_SRL;
                    10'b0100000_101: dec.alu_op = i_SRA;
                    10'b0000000_110: dec.alu_op = i_OR;
                    10'b0000000_111: dec.alu_op = i_AND;
                    default:         legal      = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                use_rs1      = 1'b1;
                has_rd       = 1'b1;
                dec.is_imm   = 1'b1;
                dec.imm      = imm_i;
                dec.alu_op   = i_ADD;
                dec.mem_re   = 1'b1;
                dec.mem_size = funct3;
                legal        = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                               (funct3 == 3'b100) || (funct3 == 3'b101);
            end
            OPC_STORE: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec.is_imm   = 1'b1;
                dec.imm      = imm_s;
                dec.alu_op   = i_ADD;
                dec.mem_we   = 1'b1;
                dec.mem_size = funct3;
                legal        = (funct3 <= 3'b010);
            end
            OPC_BRANCH: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.imm    = imm_b;
                dec.alu_op = i_SUB;
                dec.br_op  = {1'b1, funct3};
                legal      = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_JALR: begin
                use_rs1    = 1'b1;
                has_rd     = 1'b1;
                dec.is_imm = 1'b1;
                dec.imm    = imm_i;
                dec.alu_op = i_ADD;
                dec.jalr   = 1'b1;
                legal      = (funct3 == 3'b000);
            end
            OPC_JAL: begin
                has_rd     = 1'b1;
                dec.is_imm = 1'b1;
                dec.imm    = imm_j;
                dec.alu_op = i_ADD;
                dec.jal    = 1'b1;
                legal      = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                has_rd     = 1'b1;
                dec.is_imm = 1'b1;
                dec.imm    = imm_u;
                dec.alu_op = i_ADD;
                dec.lui    = (opcode == OPC_LUI);
                dec.auipc  = (opcode == OPC_AUIPC);
                legal      = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        bad_idx = (use_rs1 && idx_bad(dec.rs1)) || (use_rs2 && idx_bad(dec.rs2)) ||
                  (has_rd && idx_bad(dec.rd));

        // Illegal words still travel down the pipe so execute can raise the trap.
        if (!legal || bad_idx) begin
            dec.illegal = 1'b1;
            dec.reg_we  = 1'b0;
            dec.mem_re  = 1'b0;
            dec.mem_we  = 1'b0;
            dec.alu_op  = i_NOP;
            dec.br_op   = 4'b0;
            dec.jal     = 1'b0;
            dec.jalr    = 1'b0;
            dec.lui     = 1'b0;
            dec.auipc   = 1'b0;
        end else begin
            dec.reg_we = has_rd && (dec.rd != 5'd0);
        end
    end

    generate
        if (SB_EN) begin : g_sb
            logic [31:0] busy;
            logic [31:0] busy_nxt;
            logic        rs1_busy, rs2_busy, rd_busy;

            // A writeback landing this cycle already frees its register.
            assign rs1_busy = busy[dec.rs1] && !(wb_valid && (wb_rd == dec.rs1));
            assign rs2_busy = busy[dec.rs2] && !(wb_valid && (wb_rd == dec.rs2));
            assign rd_busy  = busy[dec.rd]  && !(wb_valid && (wb_rd == dec.rd));

            assign hazard = !dec.illegal &&
                            ((use_rs1 && rs1_busy) || (use_rs2 && rs2_busy) || (dec.reg_we && rd_busy));

            always_comb begin
                busy_nxt = busy;
                if (wb_valid)
                    busy_nxt[wb_rd] = 1'b0;
                if (flush && out_valid && out_q.reg_we)
                    busy_nxt[out_q.rd] = 1'b0;
                if (in_fire && dec.reg_we)
                    busy_nxt[dec.rd] = 1'b1;
                busy_nxt[0] = 1'b0;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    busy <= '0;
                else
                    busy <= busy_nxt;
            end
        end else begin : g_nosb
            assign hazard = 1'b0;
        end
    endgenerate

    // Handshake: a beat moves on a side only when valid && ready are both high in
    // the same cycle; valid never waits on ready, and held outputs do not change
    // while out_valid && !out_ready.
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_q     <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_pc       = out_q.pc;
    assign out_rd       = out_q.rd;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_alu_op   = out_q.alu_op;
    assign out_br_op    = out_q.br_op;
    assign out_imm      = out_q.imm;
    assign out_is_imm   = out_q.is_imm;
    assign out_reg_we   = out_q.reg_we;
    assign out_mem_re   = out_q.mem_re;
    assign out_mem_we   = out_q.mem_we;
    assign out_mem_size = out_q.mem_size;
    assign out_jal      = out_q.jal;
    assign out_jalr     = out_q.jalr;
    assign out_lui      = out_q.lui;
    assign out_auipc    = out_q.auipc;
    assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode/hazard/flush steps, an RV32E no-scoreboard
// instance, then randomized traffic against a spec-level decode and pending-write model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (RV32I, scoreboard on) ----------------
    logic        in_valid = 0, out_ready = 0, flush = 0, wb_valid = 0;
    logic [31:0] in_instr = 0, in_pc = 0;
    logic [4:0]  wb_rd = 0;
    logic        in_ready, out_valid, out_is_imm, out_reg_we, out_mem_re, out_mem_we;
    logic        out_jal, out_jalr, out_lui, out_auipc, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_br_op;
    logic [2:0]  out_mem_size;
    alu_op_t     out_alu_op;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_alu_op(out_alu_op),
        .out_br_op(out_br_op), .out_imm(out_imm), .out_is_imm(out_is_imm),
        .out_reg_we(out_reg_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
        .out_mem_size(out_mem_size), .out_jal(out_jal), .out_jalr(out_jalr),
        .out_lui(out_lui), .out_auipc(out_auipc), .out_illegal(out_illegal),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    // ---------------- second DUT (RV32E, scoreboard off) ----------------
    logic        e_in_valid = 0, e_out_ready = 0;
    logic [31:0] e_in_instr = 0, e_in_pc = 0;
    logic        e_in_ready, e_out_valid, e_out_is_imm, e_out_reg_we, e_out_mem_re, e_out_mem_we;
    logic        e_out_jal, e_out_jalr, e_out_lui, e_out_auipc, e_out_illegal;
    logic [31:0] e_out_pc, e_out_imm;
    logic [4:0]  e_out_rd, e_out_rs1, e_out_rs2;
    logic [3:0]  e_out_br_op;
    logic [2:0]  e_out_mem_size;
    alu_op_t     e_out_alu_op;

    decode_stage #(.XLEN(32), .NUM_REGS(16), .SB_EN(1'b0)) dut_e (
        .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_instr(e_in_instr),
        .in_pc(e_in_pc), .out_valid(e_out_valid), .out_ready(e_out_ready), .out_pc(e_out_pc),
        .out_rd(e_out_rd), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_alu_op(e_out_alu_op),
        .out_br_op(e_out_br_op), .out_imm(e_out_imm), .out_is_imm(e_out_is_imm),
        .out_reg_we(e_out_reg_we), .out_mem_re(e_out_mem_re), .out_mem_we(e_out_mem_we),
        .out_mem_size(e_out_mem_size), .out_jal(e_out_jal), .out_jalr(e_out_jalr),
        .out_lui(e_out_lui), .out_auipc(e_out_auipc), .out_illegal(e_out_illegal),
        .flush(1'b0), .wb_valid(1'b0), .wb_rd(5'd0)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        illegal, reg_we, mem_re, mem_we, use1, use2, is_imm;
        logic        imm_known, alu_known, isimm_known;
        logic [31:0] imm;
        alu_op_t     alu;
        logic [3:0]  br;
        logic [2:0]  msize;
        logic        jal, jalr, lui, auipc;
    } exp_t;

    bit          pend[32];
    logic [63:0] exp_q[$];

    function automatic alu_op_t base_op(input logic [2:0] f3);
        alu_op_t tab[8];
        tab = '{i_ADD, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_OR, i_AND};
        return tab[f3];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input int nregs);
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [31:0] sgn;
        bit legal, has_rd;
        e = '0; legal = 0; has_rd = 0;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        sgn = (ins[31]) ? 32'hFFFF_FFFF : 32'h0;
        case (op)
            7'h13: begin
                legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                e.use1 = 1; has_rd = 1; e.is_imm = 1;
                e.imm = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : 32'($signed(ins) >>> 20);
                e.alu = (f3 == 5 && f7 == 7'h20) ? i_SRA : base_op(f3);
                e.alu_known = 1; e.isimm_known = 1;
            end
            7'h33: begin
                legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                e.use1 = 1; e.use2 = 1; has_rd = 1; e.imm = 0;
                e.alu = (f7 == 7'h20) ? ((f3 == 0) ? i_SUB : i_SRA) : base_op(f3);
                e.alu_known = 1; e.isimm_known = 1;
            end
            7'h03: begin
                legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                e.use1 = 1; has_rd = 1; e.is_imm = 1; e.mem_re = 1; e.msize = f3;
                e.imm = 32'($signed(ins) >>> 20); e.alu = i_ADD;
                e.alu_known = 1; e.isimm_known = 1;
            end
            7'h23: begin
                legal = (f3 < 3);
                e.use1 = 1; e.use2 = 1; e.is_imm = 1; e.mem_we = 1; e.msize = f3;
                e.imm = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]); e.alu = i_ADD;
                e.alu_known = 1; e.isimm_known = 1;
            end
            7'h63: begin
                legal = !(f3 inside {3'd2, 3'd3});
                e.use1 = 1; e.use2 = 1; e.br = {1'b1, f3}; e.isimm_known = 1;
                e.imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            end
            7'h67: begin
                legal = (f3 == 0); e.use1 = 1; has_rd = 1; e.jalr = 1;
                e.imm = 32'($signed(ins) >>> 20);
            end
            7'h6F: begin
                legal = 1; has_rd = 1; e.jal = 1;
                e.imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            7'h37, 7'h17: begin
                legal = 1; has_rd = 1; e.lui = (op == 7'h37); e.auipc = (op == 7'h17);
                e.imm = ins & 32'hFFFF_F000;
            end
            default: legal = 0;
        endcase
        if (e.use1 && int'(ins[19:15]) >= nregs) legal = 0;
        if (e.use2 && int'(ins[24:20]) >= nregs) legal = 0;
        if (has_rd && int'(ins[11:7]) >= nregs) legal = 0;
        e.imm_known = legal;
        if (!legal) begin
            e.illegal = 1; e.reg_we = 0; e.mem_re = 0; e.mem_we = 0; e.use1 = 0; e.use2 = 0;
            e.alu = i_NOP; e.alu_known = 1; e.isimm_known = 0;
        end else begin
            e.reg_we = has_rd && (ins[11:7] != 0);
        end
        return e;
    endfunction

    function automatic bit reg_pending(input logic [4:0] idx);
        return (idx != 0) && pend[idx] && !(wb_valid && wb_rd == idx);
    endfunction

    function automatic bit model_hazard(input logic [31:0] ins);
        exp_t e;
        e = model(ins, 32);
        return (e.use1 && reg_pending(ins[19:15])) || (e.use2 && reg_pending(ins[24:20])) ||
               (e.reg_we && reg_pending(ins[11:7]));
    endfunction

    // ---------------- checking / driver tasks ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v; in_instr = ins; in_pc = pc;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] idx);
        wb_valid = v; wb_rd = idx;
    endtask

    task automatic check_out(input logic [63:0] item);
        exp_t e;
        logic [31:0] ins;
        ins = item[31:0];
        e = model(ins, 32);
        chk("r_pc", out_pc, item[63:32]);
        chk("r_rd", out_rd, ins[11:7]);
        chk("r_rs1", out_rs1, ins[19:15]);
        chk("r_rs2", out_rs2, ins[24:20]);
        chk("r_illegal", out_illegal, e.illegal);
        chk("r_reg_we", out_reg_we, e.reg_we);
        chk("r_mem_re", out_mem_re, e.mem_re);
        chk("r_mem_we", out_mem_we, e.mem_we);
        if (e.imm_known) chk("r_imm", out_imm, e.imm);
        if (e.alu_known) chk("r_alu", out_alu_op, e.alu);
        if (e.isimm_known) chk("r_is_imm", out_is_imm, e.is_imm);
        if (!e.illegal) begin
            chk("r_br", out_br_op, e.br);
            chk("r_msize", out_mem_size, e.msize);
            chk("r_flags", {out_jal, out_jalr, out_lui, out_auipc}, {e.jal, e.jalr, e.lui, e.auipc});
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 10);
        case (k)
            0, 9: w[6:0] = 7'h13;
            1: w[6:0] = 7'h33;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h67;
            6: w[6:0] = 7'h6F;
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;
            default: ;
        endcase
        if (k < 10) begin
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            if ((k == 0 || k == 1) && $urandom_range(0, 4) != 0)
                w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        end
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_op", out_alu_op, i_NOP);
        chk("rst_imm", out_imm, 0);
        chk("rst_reg_we", out_reg_we, 0);
        chk("rst_pc", out_pc, 0);
        step(); rst = 0;

        // addi x1,x0,5 then srai x2,x1,3 with the x1 writeback bypassed
        out_ready = 1;
        drive(1, 32'h0050_0093, 32'h100);
        @(negedge clk); chk("addi_in_ready", in_ready, 1);
        step(); drive(1, 32'h4030_D113, 32'h104); set_wb(1, 1);
        @(negedge clk);
        chk("addi_valid", out_valid, 1);
        chk("addi_rd", out_rd, 1);
        chk("addi_alu", out_alu_op, i_ADD);
        chk("addi_imm", out_imm, 5);
        chk("addi_is_imm", out_is_imm, 1);
        chk("addi_reg_we", out_reg_we, 1);
        chk("addi_pc", out_pc, 32'h100);
        chk("srai_bypass_ready", in_ready, 1);
        step(); drive(1, 32'hFE00_0EE3, 32'h108); set_wb(1, 2);
        @(negedge clk);
        chk("srai_rd", out_rd, 2);
        chk("srai_alu", out_alu_op, i_SRA);
        chk("srai_imm", out_imm, 3);
        chk("beq_ready", in_ready, 1);
        step(); drive(1, 32'h0000_03FF, 32'h10C); set_wb(0, 0);
        @(negedge clk);
        chk("beq_br_op", out_br_op, 4'b1000);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_reg_we", out_reg_we, 0);
        chk("illegal_no_stall", in_ready, 1);
        step(); drive(1, 32'h0013_8413, 32'h110);
        @(negedge clk);
        chk("illegal_flag", out_illegal, 1);
        chk("illegal_reg_we", out_reg_we, 0);
        chk("illegal_alu", out_alu_op, i_NOP);
        chk("illegal_no_busy", in_ready, 1);
        step(); drive(0, 0, 0); set_wb(1, 8);
        @(negedge clk); chk("addi_x8_rd", out_rd, 8);

        // RAW: add x3,x1,x2 then sub x4,x3,x1
        step(); drive(1, 32'h0020_81B3, 32'h200); set_wb(0, 0);
        @(negedge clk); chk("add_ready", in_ready, 1);
        step(); drive(1, 32'h4011_8233, 32'h204);
        @(negedge clk);
        chk("raw_stall0", in_ready, 0);
        chk("add_alu", out_alu_op, i_ADD);
        for (int i = 1; i <= 2; i++) begin
            step();
            @(negedge clk);
            chk("raw_stall", in_ready, 0);
            chk("raw_stall_out_valid", out_valid, 0);
        end
        step(); set_wb(1, 3);
        @(negedge clk); chk("raw_bypass", in_ready, 1);
        step(); drive(0, 0, 0); set_wb(0, 0);
        @(negedge clk);
        chk("sub_valid", out_valid, 1);
        chk("sub_rd", out_rd, 4);
        chk("sub_alu", out_alu_op, i_SUB);

        // backpressure
        step(); drive(1, 32'h0090_0493, 32'h300); set_wb(1, 4); out_ready = 0;
        @(negedge clk); chk("bp_first_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step(); drive(1, 32'h00A0_0513, 32'h304); set_wb(0, 0);
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_rd", out_rd, 9);
            chk("bp_imm", out_imm, 9);
            chk("bp_pc", out_pc, 32'h300);
            chk("bp_in_ready", in_ready, 0);
        end
        step(); out_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_rd", out_rd, 9);
        step(); drive(0, 0, 0);
        @(negedge clk);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_rd", out_rd, 10);
        chk("bp_next_pc", out_pc, 32'h304);

        // flush of held addi x5
        step(); drive(1, 32'h0050_0293, 32'h400); out_ready = 0;
        @(negedge clk); chk("fl_accept", in_ready, 1);
        step(); drive(0, 0, 0); flush = 1;
        @(negedge clk);
        chk("fl_held_rd", out_rd, 5);
        chk("fl_in_ready", in_ready, 0);
        step(); flush = 0; drive(1, 32'h0002_8593, 32'h404); out_ready = 1;
        @(negedge clk);
        chk("fl_drop", out_valid, 0);
        chk("fl_busy_clr", in_ready, 1);
        step(); drive(0, 0, 0);
        @(negedge clk); chk("fl_next_rd", out_rd, 11);

        // asynchronous reset mid-operation
        step(); drive(1, 32'h00C0_0613, 32'h500); out_ready = 0;
        step(); drive(0, 0, 0);
        @(negedge clk); chk("ar_held", out_valid, 1);
        #1 rst = 1;
        #1 chk("ar_out_valid", out_valid, 0);
        chk("ar_rd", out_rd, 0);
        step(); rst = 0; drive(1, 32'h0006_0693, 32'h504); out_ready = 1;
        @(negedge clk); chk("ar_busy_clr", in_ready, 1);
        step(); drive(0, 0, 0);
        @(negedge clk); chk("ar_next_rd", out_rd, 13);

        for (int i = 1; i < 32; i++) begin
            step(); set_wb(1, 5'(i));
        end
        step(); set_wb(0, 0);

        // RV32E, no scoreboard
        e_out_ready = 1; e_in_valid = 1; e_in_instr = 32'h0020_88B3; e_in_pc = 32'h600;
        @(negedge clk); chk("e_ready0", e_in_ready, 1);
        step(); e_in_instr = 32'h0020_81B3; e_in_pc = 32'h604;
        @(negedge clk);
        chk("e_x17_illegal", e_out_illegal, 1);
        chk("e_x17_reg_we", e_out_reg_we, 0);
        chk("e_add_ready", e_in_ready, 1);
        step(); e_in_instr = 32'h4011_8233; e_in_pc = 32'h608;
        @(negedge clk);
        chk("e_no_stall", e_in_ready, 1);
        chk("e_add_alu", e_out_alu_op, i_ADD);
        chk("e_add_legal", e_out_illegal, 0);
        step(); e_in_valid = 0;
        @(negedge clk);
        chk("e_sub_valid", e_out_valid, 1);
        chk("e_sub_rd", e_out_rd, 4);
        chk("e_sub_alu", e_out_alu_op, i_SUB);

        // randomized traffic against the model
        for (int i = 0; i < 32; i++) pend[i] = 0;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            step();
            drive(($urandom_range(0, 3) != 0), gen_instr(), $urandom & 32'hFFFF_FFFC);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                logic [4:0] pick;
                pick = 5'($urandom_range(0, 31));
                for (int j = 0; j < 32; j++)
                    if (pend[j] && $urandom_range(0, 1) == 0) pick = 5'(j);
                set_wb(1, pick);
            end else begin
                set_wb(0, 0);
            end
            @(negedge clk);
            begin
                bit exp_ready, fire, mvalid;
                exp_t e;
                mvalid = (exp_q.size() != 0);
                exp_ready = (!mvalid || out_ready) && !model_hazard(in_instr);
                chk("r_in_ready", in_ready, exp_ready);
                chk("r_out_valid", out_valid, mvalid);
                if (mvalid) check_out(exp_q[0]);
                fire = in_valid && exp_ready;
                e = model(in_instr, 32);
                if (wb_valid) pend[wb_rd] = 0;
                if (fire && e.reg_we) pend[in_instr[11:7]] = 1;
                if (mvalid && out_ready) void'(exp_q.pop_front());
                if (fire) exp_q.push_back({in_pc, in_instr});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
